// File: rtl/execute_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_pipe_if
// Description : Operation/result bundle for the execute stage. The slave
//               modport is the execute stage's view, the master modport is
//               the upstream/downstream driver's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_pipe_if #(
  parameter int N = 64
);
  // upstream operation handshake and operands
  logic         valid_i;
  logic         ready_o;
  logic [1:0]   AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic [N-1:0] readData3_E;
  // downstream result handshake and results
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] PCBranch_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] writeData_E;
  logic         zero_E;

  modport slave (
    input  valid_i, AluSrc, AluControl, PC_E, signImm_E,
           readData1_E, readData2_E, readData3_E, ready_i,
    output ready_o, valid_o, PCBranch_E, aluResult_E, writeData_E, zero_E
  );

  modport master (
    output valid_i, AluSrc, AluControl, PC_E, signImm_E,
           readData1_E, readData2_E, readData3_E, ready_i,
    input  ready_o, valid_o, PCBranch_E, aluResult_E, writeData_E, zero_E
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_pipe
// Description : Execute stage with a one-entry registered output. Single-cycle
//               ALU ops complete with 1-cycle latency and sustain one op per
//               cycle; the optional iterative shift-add multiplier (macro
//               EXEC_STAGE_MUL_EN) takes N+1 cycles from transfer to result.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_pipe #(
  parameter int N        = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  execute_stage_pipe_if.slave   bus
);

  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_PASS = 4'b0111;
  localparam logic [3:0] c_ALU_NOR  = 4'b1100;
`ifdef EXEC_STAGE_MUL_EN
  localparam logic [3:0] c_ALU_MUL  = 4'b1000;
  localparam int         c_CNT_W    = $clog2(N + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_valid;
  logic [N-1:0] r_alu;
  logic [N-1:0] r_pcbranch;
  logic [N-1:0] r_write_data;
  logic         r_zero;

  logic [N-1:0] w_op_b;
  logic [N-1:0] w_alu;
  logic [N-1:0] w_pcbranch;
  logic         w_ready;
  logic         w_xfer;

`ifdef EXEC_STAGE_MUL_EN
  logic [N-1:0]       r_mcand;
  logic [N-1:0]       r_mplier;
  logic [N-1:0]       r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic [N-1:0]       w_acc_next;

  // one shift-add step: accumulate the multiplicand when the current bit is set
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  // accept while empty, or while full and the held result leaves this cycle
  assign w_ready = (r_state == S_IDLE) || ((r_state == S_FULL) && bus.ready_i);
  assign w_xfer  = bus.valid_i && w_ready;

  assign w_pcbranch = bus.PC_E + (bus.signImm_E << BR_SHIFT);

  // operand-B select and single-cycle ALU; MUL and unknown codes give 0 here
  always_comb begin
    w_op_b = bus.readData3_E;
    case (bus.AluSrc)
      2'b00:   w_op_b = bus.readData2_E;
      2'b01:   w_op_b = bus.signImm_E;
      default: w_op_b = bus.readData3_E;
    endcase
    w_alu = '0;
    case (bus.AluControl)
      c_ALU_AND:  w_alu = bus.readData1_E & w_op_b;
      c_ALU_OR:   w_alu = bus.readData1_E | w_op_b;
      c_ALU_ADD:  w_alu = bus.readData1_E + w_op_b;
      c_ALU_SUB:  w_alu = bus.readData1_E - w_op_b;
      c_ALU_PASS: w_alu = w_op_b;
      c_ALU_NOR:  w_alu = ~(bus.readData1_E | w_op_b);
      default:    w_alu = '0;
    endcase
  end

  // control FSM with the registered result and multiplier datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_alu        <= '0;
      r_pcbranch   <= '0;
      r_write_data <= '0;
      r_zero       <= 1'b1;
`ifdef EXEC_STAGE_MUL_EN
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_FULL: begin
          if (w_xfer) begin
            // branch target and store data are final at transfer, even for MUL
            r_pcbranch   <= w_pcbranch;
            r_write_data <= bus.readData2_E;
`ifdef EXEC_STAGE_MUL_EN
            if (bus.AluControl == c_ALU_MUL) begin
              r_state  <= S_BUSY;
              r_valid  <= 1'b0;
              r_mcand  <= bus.readData1_E;
              r_mplier <= w_op_b;
              r_acc    <= '0;
              r_cnt    <= c_CNT_W'(N);
            end else begin
              r_state <= S_FULL;
              r_valid <= 1'b1;
              r_alu   <= w_alu;
              r_zero  <= (w_alu == '0);
            end
`else
            r_state <= S_FULL;
            r_valid <= 1'b1;
            r_alu   <= w_alu;
            r_zero  <= (w_alu == '0);
`endif
          end else if ((r_state == S_FULL) && bus.ready_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
`ifdef EXEC_STAGE_MUL_EN
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - c_CNT_W'(1);
          // last multiplier bit: publish the product
          if (r_cnt == c_CNT_W'(1)) begin
            r_state <= S_FULL;
            r_valid <= 1'b1;
            r_alu   <= w_acc_next;
            r_zero  <= (w_acc_next == '0);
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.valid_o     = r_valid;
  assign bus.aluResult_E = r_alu;
  assign bus.PCBranch_E  = r_pcbranch;
  assign bus.writeData_E = r_write_data;
  assign bus.zero_E      = r_zero;

endmodule
`default_nettype wire
